axis_lockstep_checker: RTL and testbench

Multi-stream AXI4-Stream lock-step checker: joins N_IN sink streams beat by beat and compares every stream against stream 0 (data and last). It keeps a sticky pass/fail flag, saturating beat and mismatch counters, and a capture of the first failing beat. It sits at the end of the datapath in self-check and loopback builds, fed by the golden model output and one or more DUT outputs.

---
 rtl/axis_check_pkg.sv | 23 ++
 rtl/axis_join.sv | 19 +
 rtl/axis_lockstep_checker.sv | 136 +++++++++++++
 tb/tb_axis_lockstep_checker.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_check_pkg.sv
// Shared types and helpers for the multi-stream AXI4-Stream checkers.
package axis_check_pkg;

    // Checker progress: IDLE until the first good beat, RUN while all beats
    // match, FAIL (terminal until reset/clear) after any miscompare.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAIL = 2'd2
    } check_state_t;

    // Widest counter sat_inc can handle.
    localparam int unsigned SAT_W = 64;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                                 input int unsigned      w);
        logic [SAT_W-1:0] max_v;
        max_v = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
        return (v == max_v) ? v : v + SAT_W'(1);
    endfunction

endpackage

// File: rtl/axis_join.sv
// N-way valid/ready join: all streams are consumed together or not at all.
module axis_join
    import axis_check_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         en,
    input  logic [N-1:0] valid,
    output logic [N-1:0] ready,
    output logic         fire
);

    // A beat fires only when enabled and every stream offers one.
    always_comb begin
        fire  = en & (&valid);
        ready = {N{fire}};
    end

endmodule

// File: rtl/axis_lockstep_checker.sv
// Lock-step checker: joins N_IN streams and compares each against stream 0,
// keeping a sticky verdict, saturating stats and a first-error capture.
module axis_lockstep_checker
    import axis_check_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [N_IN-1:0][DATA_W-1:0]   s_axis_tdata,
    input  logic [N_IN-1:0]               s_axis_tvalid,
    input  logic [N_IN-1:0]               s_axis_tlast,
    output logic [N_IN-1:0]               s_axis_tready,
    input  logic                          clear,
    output logic                          equal,
    output logic [1:0]                    state,
    output logic [CNT_W-1:0]              beat_cnt,
    output logic [CNT_W-1:0]              mismatch_cnt,
    output logic [CNT_W-1:0]              first_err_beat,
    output logic [N_IN-1:0]               first_err_mask,
    output logic                          pkt_done
);

    if (N_IN < 2 || N_IN > 8) begin : g_bad_n_in
        $error("axis_lockstep_checker: N_IN must be 2..8");
    end
    if (CNT_W < 1 || CNT_W > SAT_W) begin : g_bad_cnt_w
        $error("axis_lockstep_checker: CNT_W must be 1..64");
    end

    logic                 fire;
    logic [N_IN-1:0]      miss;
    logic                 beat_bad;
    check_state_t         state_q, state_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]     mismatch_cnt_q, mismatch_cnt_d;
    logic [CNT_W-1:0]     first_err_beat_q, first_err_beat_d;
    logic [N_IN-1:0]      first_err_mask_q, first_err_mask_d;
    logic                 pkt_done_q, pkt_done_d;

    // Readies are held low in reset and while clear is asserted, so clear
    // always wins over a beat offered in the same cycle.
    axis_join #(.N(N_IN)) u_join (
        .en    (resetn & ~clear),
        .valid (s_axis_tvalid),
        .ready (s_axis_tready),
        .fire  (fire)
    );

    // Per-stream miscompare against the golden stream 0 (bit 0 is never set).
    always_comb begin
        miss = '0;
        for (int i = 1; i < N_IN; i++) begin
            miss[i] = (s_axis_tdata[i] != s_axis_tdata[0]) |
                      (s_axis_tlast[i] != s_axis_tlast[0]);
        end
        beat_bad = |miss;
    end

    // FSM state register; clear acts exactly like reset.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: advances only on a consumed beat; FAIL is terminal.
    always_comb begin
        state_d = state_q;
        if (fire) begin
            case (state_q)
                ST_IDLE: state_d = beat_bad ? ST_FAIL : ST_RUN;
                ST_RUN:  state_d = beat_bad ? ST_FAIL : ST_RUN;
                default: state_d = ST_FAIL;
            endcase
        end
    end

    // FSM outputs: the verdict is a pure decode of the registered state.
    always_comb begin
        state = state_q;
        equal = (state_q != ST_FAIL);
    end

    // Stats, first-error capture and packet-end pulse for the current beat.
    always_comb begin
        beat_cnt_d       = beat_cnt_q;
        mismatch_cnt_d   = mismatch_cnt_q;
        first_err_beat_d = first_err_beat_q;
        first_err_mask_d = first_err_mask_q;
        pkt_done_d       = 1'b0;
        if (fire) begin
            beat_cnt_d = CNT_W'(sat_inc(SAT_W'(beat_cnt_q), CNT_W));
            if (beat_bad) begin
                mismatch_cnt_d = CNT_W'(sat_inc(SAT_W'(mismatch_cnt_q), CNT_W));
            end
            // Not yet in FAIL means this is the first bad beat since restart.
            if (beat_bad && state_q != ST_FAIL) begin
                first_err_beat_d = beat_cnt_q;
                first_err_mask_d = miss;
            end
            pkt_done_d = s_axis_tlast[0];
        end
    end

    // Stats registers; reset/clear return every statistic to zero.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            beat_cnt_q       <= '0;
            mismatch_cnt_q   <= '0;
            first_err_beat_q <= '0;
            first_err_mask_q <= '0;
            pkt_done_q       <= 1'b0;
        end else begin
            beat_cnt_q       <= beat_cnt_d;
            mismatch_cnt_q   <= mismatch_cnt_d;
            first_err_beat_q <= first_err_beat_d;
            first_err_mask_q <= first_err_mask_d;
            pkt_done_q       <= pkt_done_d;
        end
    end

    // Registered stats drive the outputs directly.
    always_comb begin
        beat_cnt       = beat_cnt_q;
        mismatch_cnt   = mismatch_cnt_q;
        first_err_beat = first_err_beat_q;
        first_err_mask = first_err_mask_q;
        pkt_done       = pkt_done_q;
    end

endmodule

// File: tb/tb_axis_lockstep_checker.sv
// Bench for axis_lockstep_checker: two instances share one stimulus,
// a 3-stream/32-bit-counter checker and a 2-stream/4-bit-counter checker
// (the latter sees streams 0 and 1 only).
module tb_axis_lockstep_checker;

    typedef struct {
        logic [31:0] bc3, mc3, feb3;
        logic [2:0]  fem3;
        logic [1:0]  st3;
        logic [3:0]  bc4, mc4, feb4;
        logic [1:0]  fem4;
        logic [1:0]  st4;
        logic        pd;
    } exp_t;

    logic             clk = 1'b0;
    logic             resetn, clear;
    logic [2:0]       vld, lst;
    logic [2:0][63:0] dat;

    logic [2:0]  rdy3, fem3;
    logic        eq3, pd3;
    logic [1:0]  st3;
    logic [31:0] bc3, mc3, feb3;
    logic [1:0]  rdy4, fem4, st4;
    logic        eq4, pd4;
    logic [3:0]  bc4, mc4, feb4;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t mdl;
    exp_t sb[$];

    always #5 clk = ~clk;

    axis_lockstep_checker #(.N_IN(3), .DATA_W(64), .CNT_W(32)) dut3 (
        .clk(clk), .resetn(resetn),
        .s_axis_tdata(dat), .s_axis_tvalid(vld), .s_axis_tlast(lst),
        .s_axis_tready(rdy3), .clear(clear),
        .equal(eq3), .state(st3), .beat_cnt(bc3), .mismatch_cnt(mc3),
        .first_err_beat(feb3), .first_err_mask(fem3), .pkt_done(pd3)
    );

    axis_lockstep_checker #(.N_IN(2), .DATA_W(64), .CNT_W(4)) dut4 (
        .clk(clk), .resetn(resetn),
        .s_axis_tdata(dat[1:0]), .s_axis_tvalid(vld[1:0]), .s_axis_tlast(lst[1:0]),
        .s_axis_tready(rdy4), .clear(clear),
        .equal(eq4), .state(st4), .beat_cnt(bc4), .mismatch_cnt(mc4),
        .first_err_beat(feb4), .first_err_mask(fem4), .pkt_done(pd4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mdl_reset();
        exp_t e;
        e.bc3 = '0; e.mc3 = '0; e.feb3 = '0; e.fem3 = '0; e.st3 = 2'd0;
        e.bc4 = '0; e.mc4 = '0; e.feb4 = '0; e.fem4 = '0; e.st4 = 2'd0;
        e.pd  = 1'b0;
        return e;
    endfunction

    task automatic cmp_all(input exp_t e, input string p);
        chk({p, ".st3"},  64'(st3),  64'(e.st3));
        chk({p, ".eq3"},  64'(eq3),  64'(e.st3 != 2'd2));
        chk({p, ".bc3"},  64'(bc3),  64'(e.bc3));
        chk({p, ".mc3"},  64'(mc3),  64'(e.mc3));
        chk({p, ".feb3"}, 64'(feb3), 64'(e.feb3));
        chk({p, ".fem3"}, 64'(fem3), 64'(e.fem3));
        chk({p, ".pd3"},  64'(pd3),  64'(e.pd));
        chk({p, ".st4"},  64'(st4),  64'(e.st4));
        chk({p, ".eq4"},  64'(eq4),  64'(e.st4 != 2'd2));
        chk({p, ".bc4"},  64'(bc4),  64'(e.bc4));
        chk({p, ".mc4"},  64'(mc4),  64'(e.mc4));
        chk({p, ".feb4"}, 64'(feb4), 64'(e.feb4));
        chk({p, ".fem4"}, 64'(fem4), 64'(e.fem4));
        chk({p, ".pd4"},  64'(pd4),  64'(e.pd));
    endtask

    // Reference behaviour for one consumed beat on both instances; the
    // resulting expected outputs go to the scoreboard.
    task automatic model_beat();
        logic [2:0] miss;
        logic       bad3, bad4;
        miss = 3'b000;
        for (int i = 1; i < 3; i++)
            miss[i] = (dat[i] != dat[0]) || (lst[i] != lst[0]);
        bad3 = (miss != 3'b000);
        bad4 = miss[1];
        if (bad3 && mdl.st3 != 2'd2) begin mdl.feb3 = mdl.bc3; mdl.fem3 = miss; end
        if (bad3) mdl.st3 = 2'd2; else if (mdl.st3 == 2'd0) mdl.st3 = 2'd1;
        if (mdl.bc3 != 32'hFFFF_FFFF) mdl.bc3 = mdl.bc3 + 32'd1;
        if (bad3 && mdl.mc3 != 32'hFFFF_FFFF) mdl.mc3 = mdl.mc3 + 32'd1;
        if (bad4 && mdl.st4 != 2'd2) begin mdl.feb4 = mdl.bc4; mdl.fem4 = miss[1:0]; end
        if (bad4) mdl.st4 = 2'd2; else if (mdl.st4 == 2'd0) mdl.st4 = 2'd1;
        if (mdl.bc4 != 4'hF) mdl.bc4 = mdl.bc4 + 4'd1;
        if (bad4 && mdl.mc4 != 4'hF) mdl.mc4 = mdl.mc4 + 4'd1;
        mdl.pd = lst[0];
        sb.push_back(mdl);
    endtask

    // Offer one joined beat on all streams; valids stay high afterwards so
    // back-to-back calls run at full throughput.
    task automatic beat(input logic [63:0] d0, d1, d2, input logic [2:0] l);
        dat = {d2, d1, d0};
        lst = l;
        vld = 3'b111;
        model_beat();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        vld = 3'b000;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input string p);
        vld   = 3'b000;
        clear = 1'b1;
        mdl   = mdl_reset();
        @(posedge clk); #1;
        clear = 1'b0;
        cmp_all(mdl, p);
    endtask

    // Monitor: readies every edge, scoreboard pop one cycle after each fire.
    always @(posedge clk) begin : mon
        logic f;
        f = resetn && !clear && (vld == 3'b111);
        chk("rdy3", 64'(rdy3), 64'({3{f}}));
        chk("rdy4", 64'(rdy4), 64'({2{f}}));
        #1;
        if (f) begin
            if (sb.size() == 0) chk("sb_pop", 64'(sb.size()), 64'd1);
            else cmp_all(sb.pop_front(), "beat");
        end else if (resetn) begin
            chk("pd3_idle", 64'(pd3), 64'd0);
            chk("pd4_idle", 64'(pd4), 64'd0);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [63:0] d;
        resetn = 1'b0; clear = 1'b0; vld = 3'b000; lst = 3'b000; dat = '0;
        mdl = mdl_reset();
        repeat (3) @(posedge clk);
        #1;
        cmp_all(mdl, "rst");
        resetn = 1'b1;
        @(posedge clk); #1;

        // Identical 16-beat packet, last on beat 15.
        for (int b = 0; b < 16; b++) begin
            d = {$urandom, $urandom};
            beat(d, d, d, (b == 15) ? 3'b111 : 3'b000);
        end
        idle(2);
        do_clear("clr1");

        // Stream 2 differs at beat 5 only, 10 beats.
        for (int b = 0; b < 10; b++) begin
            d = {$urandom, $urandom};
            beat(d, d, (b == 5) ? (d ^ 64'h1) : d, (b == 9) ? 3'b111 : 3'b000);
        end
        idle(2);
        do_clear("clr2");

        // Stream 1 (and 2) valid delayed 3 cycles behind stream 0.
        d   = {$urandom, $urandom};
        dat = {d, d, d};
        lst = 3'b111;
        vld = 3'b001;
        repeat (3) @(posedge clk);
        #1;
        vld = 3'b111;
        model_beat();
        @(posedge clk); #1;
        idle(2);
        do_clear("clr3");

        // last on stream 1 at beat 7, on streams 0/2 at beat 8, data equal.
        for (int b = 0; b < 9; b++) begin
            d = {$urandom, $urandom};
            beat(d, d, d, {(b == 8), (b == 7), (b == 8)});
        end
        idle(2);
        do_clear("clr4");

        // 20 matching beats: the 4-bit counter must hold at 15.
        for (int b = 0; b < 20; b++) begin
            d = {$urandom, $urandom};
            beat(d, d, d, (b == 19) ? 3'b111 : 3'b000);
        end
        idle(2);
        do_clear("clr5");

        // Build up failing state, then clear against a valid mismatching beat.
        for (int b = 0; b < 3; b++) begin
            d = {$urandom, $urandom};
            beat(d, ~d, ~d, 3'b000);
        end
        d     = {$urandom, $urandom};
        dat   = {~d, ~d, d};
        lst   = 3'b000;
        vld   = 3'b111;
        clear = 1'b1;
        mdl   = mdl_reset();
        @(posedge clk); #1;
        clear = 1'b0;
        vld   = 3'b000;
        cmp_all(mdl, "clr_mm");
        d = {$urandom, $urandom};
        beat(d, d, d, 3'b111);
        idle(1);

        // Reset mid-packet: the next fire counts as beat 0.
        for (int b = 0; b < 3; b++) begin
            d = {$urandom, $urandom};
            beat(d, d, d, 3'b000);
        end
        resetn = 1'b0;
        mdl    = mdl_reset();
        @(posedge clk); #1;
        resetn = 1'b1;
        vld    = 3'b000;
        cmp_all(mdl, "rst_mid");
        d = {$urandom, $urandom};
        beat(d, d, d ^ 64'h80, 3'b111);
        idle(2);

        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
